// File: rtl/instr_field_decode_pkg.sv
// ============================================================================
// Module  : instr_field_decode_pkg
// Purpose : Shared widths, opcodes, field positions and decoded-entry layout.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_field_decode_pkg;

    localparam int XLEN = 32;
    localparam int JT_W = 26;

    localparam logic [5:0] OPC_J   = 6'h02;
    localparam logic [5:0] OPC_JAL = 6'h03;

    // LSB positions of each instruction field
    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_W     = 16;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] jump_addr;
        logic            is_jump;
        logic            is_link;
    } dec_entry_t;

    localparam int ENTRY_W = $bits(dec_entry_t);

endpackage

`default_nettype wire

// File: rtl/instr_field_split.sv
// ============================================================================
// Module  : instr_field_split
// Purpose : Pure combinational split of an instruction word into decoded fields.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_split
    import instr_field_decode_pkg::*;
(
    input  logic [XLEN-1:0]    instr_i,
    input  logic [XLEN-1:0]    pc_i,
    output logic [ENTRY_W-1:0] entry_o
);

    dec_entry_t w_entry;

    always_comb begin
        w_entry           = '0;
        w_entry.pc        = pc_i;
        w_entry.opcode    = instr_i[OPC_LSB   +: 6];
        w_entry.rs        = instr_i[RS_LSB    +: 5];
        w_entry.rt        = instr_i[RT_LSB    +: 5];
        w_entry.rd        = instr_i[RD_LSB    +: 5];
        w_entry.shamt     = instr_i[SHAMT_LSB +: 5];
        w_entry.funct     = instr_i[FUNCT_LSB +: 6];
        w_entry.imm       = {{(XLEN-IMM_W){instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0]};
        // Word target is zero-extended; the PC-select mux does any shifting
        w_entry.jump_addr = {{(XLEN-JT_W){1'b0}}, instr_i[JT_W-1:0]};
        w_entry.is_jump   = (instr_i[OPC_LSB +: 6] == OPC_J) ||
                            (instr_i[OPC_LSB +: 6] == OPC_JAL);
        w_entry.is_link   = (instr_i[OPC_LSB +: 6] == OPC_JAL);
    end

    assign entry_o = w_entry;

endmodule

`default_nettype wire

// File: rtl/instr_field_decode.sv
// ============================================================================
// Module  : instr_field_decode
// Purpose : Instruction field decoder with a 2-entry skid queue (head in slot 0).
//           Optional DECODE_STALL_CNT_EN adds a saturating stall_cnt output.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_decode
    import instr_field_decode_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] jump_addr,
    output logic            is_jump,
    output logic            is_link
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    logic [ENTRY_W-1:0] w_new_raw;
    dec_entry_t         w_new;

    dec_entry_t  head_q, head_d;
    dec_entry_t  tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        w_push;
    logic        w_pop;

    instr_field_split u_split (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .entry_o (w_new_raw)
    );

    assign w_new  = dec_entry_t'(w_new_raw);
    assign w_push = in_valid && in_ready_q && !flush;
    assign w_pop  = out_valid_q && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // Storage keeps stale contents; only occupancy is cleared
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (w_push) begin
                        head_d  = w_new;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push) begin
                        if (w_pop) begin
                            head_d = w_new;
                        end else begin
                            tail_d  = w_new;
                            count_d = 2'd2;
                        end
                    end else if (w_pop) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = head_q.pc;
    assign opcode    = head_q.opcode;
    assign rs        = head_q.rs;
    assign rt        = head_q.rt;
    assign rd        = head_q.rd;
    assign shamt     = head_q.shamt;
    assign funct     = head_q.funct;
    assign imm       = head_q.imm;
    assign jump_addr = head_q.jump_addr;
    assign is_jump   = head_q.is_jump;
    assign is_link   = head_q.is_link;

`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_field_decode.sv
// ============================================================================
// Module  : tb_instr_field_decode
// Purpose : Self-checking bench: directed vector table, corner sequences and
//           randomized traffic against a queue-based reference model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_field_decode;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [31:0] jump_addr;
    logic        is_jump;
    logic        is_link;
`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    instr_field_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm       (imm),
        .jump_addr (jump_addr),
        .is_jump   (is_jump),
        .is_link   (is_link)
`ifdef DECODE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [31:0] jump_addr;
        logic        is_jump;
        logic        is_link;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] ja;
        logic        ij;
        logic        il;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    exp_t        mq[$];
    exp_t        shown;
    bit          rdy_m;
    int unsigned stall_m;

    function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc);
        exp_t        e;
        int unsigned u;
        int unsigned lo16;
        u           = ins;
        lo16        = u % 65536;
        e.pc        = pc;
        e.opcode    = 6'(u / 67108864);
        e.rs        = 5'((u / 2097152) % 32);
        e.rt        = 5'((u / 65536) % 32);
        e.rd        = 5'((u / 2048) % 32);
        e.shamt     = 5'((u / 64) % 32);
        e.funct     = 6'(u % 64);
        e.imm       = (lo16 >= 32768) ? (32'hFFFF_0000 | lo16) : lo16;
        e.jump_addr = u % 67108864;
        e.is_jump   = (e.opcode == 6'd2) || (e.opcode == 6'd3);
        e.is_link   = (e.opcode == 6'd3);
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        shown   = '0;
        rdy_m   = 1'b1;
        stall_m = 0;
    endtask

    task automatic model_step();
        bit push;
        bit pop;
        push = in_valid && rdy_m && !flush;
        pop  = (mq.size() != 0) && out_ready;
        if ((mq.size() != 0) && !out_ready && (stall_m != 65535)) stall_m++;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(ref_decode(in_instr, in_pc));
        end
        rdy_m = (mq.size() != 2);
        if (mq.size() != 0) shown = mq[0];
    endtask

    task automatic chk(string name, logic [159:0] act, logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [129:0] dut_fields();
        return {out_pc, opcode, rs, rt, rd, shamt, funct, imm, jump_addr, is_jump, is_link};
    endfunction

    task automatic check_model(string tag);
        chk({tag, ".out_valid"}, 160'(out_valid), 160'(mq.size() != 0));
        chk({tag, ".in_ready"},  160'(in_ready),  160'(rdy_m));
        chk({tag, ".fields"},    160'(dut_fields()), 160'(shown));
`ifdef DECODE_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, 160'(stall_cnt), 160'(stall_m));
`endif
    endtask

    // One clock: apply inputs, advance model at the edge, compare just after
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input string tag);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    vec_t vecs[4];

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        model_reset();

        vecs[0] = '{32'h0800_1234, 32'h40, 6'd2, 5'd0,  5'd0,  5'd2,  32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0};
        vecs[1] = '{32'h2022_FFFC, 32'h44, 6'd8, 5'd1,  5'd2,  5'd31, 32'hFFFF_FFFC, 32'h0022_FFFC, 1'b0, 1'b0};
        vecs[2] = '{32'h0C3F_FFFF, 32'h48, 6'd3, 5'd1,  5'd31, 5'd31, 32'hFFFF_FFFF, 32'h003F_FFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h012A_4020, 32'h4C, 6'd0, 5'd9,  5'd10, 5'd8,  32'h0000_4020, 32'h012A_4020, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready",  160'(in_ready),  160'(1'b1));
        chk("reset.out_valid", 160'(out_valid), 160'(1'b0));
        chk("reset.fields",    160'(dut_fields()), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed decode table, one beat at a time into an empty queue
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0, "vec_push");
            chk("vec.out_valid", 160'(out_valid), 160'(1'b1));
            chk("vec.out_pc",    160'(out_pc),    160'(vecs[i].pc));
            chk("vec.opcode",    160'(opcode),    160'(vecs[i].opc));
            chk("vec.rs",        160'(rs),        160'(vecs[i].rs));
            chk("vec.rt",        160'(rt),        160'(vecs[i].rt));
            chk("vec.rd",        160'(rd),        160'(vecs[i].rd));
            chk("vec.imm",       160'(imm),       160'(vecs[i].imm));
            chk("vec.jump_addr", 160'(jump_addr), 160'(vecs[i].ja));
            chk("vec.is_jump",   160'(is_jump),   160'(vecs[i].ij));
            chk("vec.is_link",   160'(is_link),   160'(vecs[i].il));
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "vec_drain");
            chk("vec.drained", 160'(out_valid), 160'(1'b0));
        end

        // Stall: three beats offered, two accepted, head held, order on drain
        cyc(1'b1, 32'h1111_0001, 32'h100, 1'b0, 1'b0, "stall");
        cyc(1'b1, 32'h2222_0002, 32'h104, 1'b0, 1'b0, "stall");
        chk("stall.in_ready_full", 160'(in_ready), 160'(1'b0));
        cyc(1'b1, 32'h3333_0003, 32'h108, 1'b0, 1'b0, "stall");
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "stall");
        chk("stall.head_held", 160'(out_pc), 160'(32'h100));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
        chk("drain.second", 160'(out_pc), 160'(32'h104));
        chk("drain.in_ready", 160'(in_ready), 160'(1'b1));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
        chk("drain.empty", 160'(out_valid), 160'(1'b0));

        // Streaming: one output per cycle, no bubbles
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, $urandom, 32'h200 + 32'(4 * i), 1'b1, 1'b0, "stream");
            chk("stream.valid", 160'(out_valid), 160'(1'b1));
            chk("stream.pc",    160'(out_pc),    160'(32'h200 + 32'(4 * i)));
        end
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "stream_end");

        // Flush with a full queue and a beat offered in the same cycle
        cyc(1'b1, 32'h0800_0AAA, 32'h300, 1'b0, 1'b0, "pre_flush");
        cyc(1'b1, 32'h0800_0BBB, 32'h304, 1'b0, 1'b0, "pre_flush");
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "pre_flush");
        cyc(1'b1, 32'h0800_0CCC, 32'h308, 1'b1, 1'b1, "flush");
        chk("flush.out_valid", 160'(out_valid), 160'(1'b0));
        chk("flush.in_ready",  160'(in_ready),  160'(1'b1));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "post_flush");
        chk("post_flush.empty", 160'(out_valid), 160'(1'b0));
        cyc(1'b1, 32'h0800_0DDD, 32'h30C, 1'b1, 1'b0, "post_flush");
        chk("post_flush.new_head", 160'(out_pc), 160'(32'h30C));
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "post_flush");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), "rand");
        end

        // Reset mid-transfer clears outputs without waiting for a clock
        cyc(1'b1, 32'hFFFF_FFFF, 32'h500, 1'b0, 1'b0, "pre_rst");
        cyc(1'b1, 32'h0C00_0001, 32'h504, 1'b0, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.out_valid", 160'(out_valid), 160'(1'b0));
        chk("midrst.in_ready",  160'(in_ready),  160'(1'b1));
        chk("midrst.fields",    160'(dut_fields()), 160'(0));
`ifdef DECODE_STALL_CNT_EN
        chk("midrst.stall_cnt", 160'(stall_cnt), 160'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h2022_FFFC, 32'h600, 1'b1, 1'b0, "after_rst");
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
